// File: rtl/sliscp_inv_step.sv
// rtl/sliscp_inv_step.sv - iterative inverse of one sLiSCP-light step
// Two inverse Simeck boxes each run one round per cycle; s0/s2 are resolved at accept.
module sliscp_inv_step #(
  parameter int WIDTH  = 48,
  parameter int ROUNDS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*WIDTH-1:0]   sin,
  input  logic [7:0]           rc1,
  input  logic [7:0]           rc0,
  input  logic [7:0]           sc1,
  input  logic [7:0]           sc0,
  output logic                 busy,
  output logic                 done,
  output logic [4*WIDTH-1:0]   sout
);

  localparam int H = WIDTH / 2;
  localparam logic [2:0] LAST = 3'(ROUNDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [2:0]       cnt;
  logic [7:0]       rc0_q;
  logic [7:0]       rc1_q;
  logic [WIDTH-1:0] box0;
  logic [WIDTH-1:0] box1;
  logic [WIDTH-1:0] box0_nxt;
  logic [WIDTH-1:0] box1_nxt;
  logic [WIDTH-1:0] t0, t1, t2, t3;
  logic             unused_sc_bits;

  function automatic logic [H-1:0] rol(input logic [H-1:0] x, input int n);
    return (x << n) | (x >> (H - n));
  endfunction

  function automatic logic [H-1:0] simeck_f(input logic [H-1:0] x);
    return (x & rol(x, 5)) ^ rol(x, 1);
  endfunction

  // (l', r') -> (r', l' ^ f(r') ^ c_j)
  function automatic logic [WIDTH-1:0] inv_round(input logic [WIDTH-1:0] x,
                                                 input logic rc_bit);
    logic [H-1:0] l, r, c;
    l = x[WIDTH-1:H];
    r = x[H-1:0];
    c = {{(H-1){1'b1}}, rc_bit};
    return {r, l ^ simeck_f(r) ^ c};
  endfunction

  function automatic logic [WIDTH-1:0] step_const(input logic [7:0] sc);
    return {{(WIDTH-8){1'b1}}, 2'b00, sc[5:0]};
  endfunction

  assign t0 = sin[4*WIDTH-1:3*WIDTH];
  assign t1 = sin[3*WIDTH-1:2*WIDTH];
  assign t2 = sin[2*WIDTH-1:WIDTH];
  assign t3 = sin[WIDTH-1:0];

  // Rounds run from ROUNDS-1 down to 0, so the counter doubles as the round index.
  assign box0_nxt = inv_round(box0, rc0_q[cnt]);
  assign box1_nxt = inv_round(box1, rc1_q[cnt]);

  assign unused_sc_bits = ^{sc0[7:6], sc1[7:6]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sout  <= '0;
      box0  <= '0;
      box1  <= '0;
      rc0_q <= '0;
      rc1_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sout[4*WIDTH-1:3*WIDTH] <= t3 ^ t0 ^ step_const(sc0);
            sout[2*WIDTH-1:WIDTH]   <= t1 ^ t2 ^ step_const(sc1);
            box0  <= t0;
            box1  <= t2;
            rc0_q <= rc0;
            rc1_q <= rc1;
            cnt   <= LAST;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          box0 <= box0_nxt;
          box1 <= box1_nxt;
          if (cnt == 3'd0) begin
            sout[3*WIDTH-1:2*WIDTH] <= box0_nxt;
            sout[WIDTH-1:0]         <= box1_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
